// File: rtl/isqrt_pkg.sv
// Shared types, widths and helpers for the iterative integer square root.
package isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned X_W   = 32'd32;
  localparam int unsigned Y_W   = 32'd16;
  localparam int unsigned REM_W = 32'd19;
  localparam int unsigned CNT_W = 32'd4;

  // Number of BUSY cycles needed to resolve all root bits.
  function automatic int unsigned iter_of(input int unsigned bpc);
    return Y_W / bpc;
  endfunction

  // Only divisors of the root width that keep the counter in range are supported.
  function automatic bit bpc_legal(input int unsigned bpc);
    return (bpc == 32'd1) || (bpc == 32'd2) || (bpc == 32'd4);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit step: brings down two operand bits and
// resolves one root bit.
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic [Y_W-1:0]   root,
  input  logic [1:0]       x_top,
  output logic [REM_W-1:0] rem_next,
  output logic [Y_W-1:0]   root_next
);

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             unused_rem_hi;

  // The remainder never exceeds 2*root, so its two top bits are always zero
  // and drop out when the next operand pair is shifted in.
  assign unused_rem_hi = ^rem[REM_W-1:REM_W-2];

  // Trial subtraction of {root, 01} against the extended remainder.
  always_comb begin
    rem_sh = {rem[REM_W-3:0], x_top};
    trial  = {1'b0, root, 2'b01};
    if (rem_sh >= trial) begin
      rem_next  = rem_sh - trial;
      root_next = {root[Y_W-2:0], 1'b1};
    end else begin
      rem_next  = rem_sh;
      root_next = {root[Y_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_iter.sv
// Iterative floor square root of a 32-bit operand, BITS_PER_CYCLE root bits
// per clock, one operation in flight, back-to-back issue from ST_DONE.
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 32'd1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [X_W-1:0] x,
  output logic           y_vld,
  output logic [Y_W-1:0] y,
  output logic           busy
);

  localparam int unsigned      ITER     = iter_of(BITS_PER_CYCLE);
  localparam int unsigned      SH_W     = 32'd2 * BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 32'd1);

  if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("isqrt_iter: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e           state_q, state_d;
  logic [X_W-1:0]   op_q, op_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [Y_W-1:0]   root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             y_vld_q, y_vld_d;

  logic [X_W-1:0]   op_shift;
  logic [REM_W-1:0] rem_c  [BITS_PER_CYCLE+1];
  logic [Y_W-1:0]   root_c [BITS_PER_CYCLE+1];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;
  assign op_shift  = {op_q[X_W-1-SH_W:0], {SH_W{1'b0}}};

  // Chain of steps; step i consumes the i-th operand bit pair from the top.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    isqrt_step u_step (
      .rem       (rem_c[i]),
      .root      (root_c[i]),
      .x_top     (op_q[X_W-1-2*i -: 2]),
      .rem_next  (rem_c[i+1]),
      .root_next (root_c[i+1])
    );
  end

  // Next state, operand load / iteration advance and result capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (x_vld) begin
          state_d = ST_BUSY;
          op_d    = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        op_d   = op_shift;
        rem_d  = rem_c[BITS_PER_CYCLE];
        root_d = root_c[BITS_PER_CYCLE];
        cnt_d  = cnt_q + CNT_W'(1'b1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          y_d     = root_c[BITS_PER_CYCLE];
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    y_vld_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset; reset drops any
  // operation in flight without producing a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign y_vld = y_vld_q;
  assign y     = y_q;
  assign busy  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_isqrt_iter.sv
// Scoreboard bench for isqrt_iter, one instance per legal BITS_PER_CYCLE.
module tb_isqrt_iter;

  localparam int N_DUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld_a [N_DUT];
  logic [31:0] x_a     [N_DUT];
  logic        y_vld_a [N_DUT];
  logic [15:0] y_a     [N_DUT];
  logic        busy_a  [N_DUT];

  int iter_a [N_DUT];
  int cur   = 0;
  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] x;
    logic [15:0] y;
    int          due;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  // Cycle counter used to timestamp issue and result cycles.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int unsigned BPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    isqrt_iter #(.BITS_PER_CYCLE(BPC)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld_a[g]),
      .x     (x_a[g]),
      .y_vld (y_vld_a[g]),
      .y     (y_a[g]),
      .busy  (busy_a[g])
    );
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d, cycle %0d): got %0d, expected %0d", tag, cur, cyc, obs, exp);
    end
  endtask

  // Reference: binary search on 64-bit squares.
  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    longint unsigned lo, hi, mid, vv;
    lo = 0;
    hi = 65535;
    vv = v;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= vv) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  function automatic logic root_ok(input logic [31:0] v, input logic [15:0] r);
    longint unsigned rr, vv;
    rr = r;
    vv = v;
    return (rr * rr <= vv) && (vv < (rr + 1) * (rr + 1));
  endfunction

  // Result monitor: every y_vld pops one expectation and checks value, timing, bounds.
  always @(negedge clk) begin
    if (y_vld_a[cur] === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_eq("spurious_y_vld", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk_eq("y", y_a[cur], mon_e.y);
        chk_eq("latency", cyc, mon_e.due);
        chk_eq("root_bounds", root_ok(mon_e.x, y_a[cur]), 64'd1);
      end
    end
  end

  // Drive x_vld for one cycle in the current cycle; push expectation if it will be accepted.
  task automatic issue(input logic [31:0] v, input bit accepted);
    exp_t e;
    x_a[cur]     = v;
    x_vld_a[cur] = 1'b1;
    if (accepted) begin
      e.x   = v;
      e.y   = ref_isqrt(v);
      e.due = cyc + iter_a[cur] + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    x_vld_a[cur] = 1'b0;
  endtask

  task automatic drain(output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(negedge clk);
      if (busy_a[cur] === 1'b1) busy_cycles++;
      n++;
    end
    chk_eq("drain_pending", exp_q.size(), 64'd0);
    exp_q.delete();
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir_v [5];
    int          bc;
    int          w;
    int          k_rst;
    int          n_rand;
    logic [31:0] v;

    dir_v[0] = 32'd0;
    dir_v[1] = 32'd1000000;
    dir_v[2] = 32'd15;
    dir_v[3] = 32'd16;
    dir_v[4] = 32'hFFFF_FFFF;

    rst = 1'b1;
    for (int g = 0; g < N_DUT; g++) begin
      x_vld_a[g] = 1'b0;
      x_a[g]     = 32'd0;
      iter_a[g]  = 16 / (1 << g);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N_DUT; g++) begin
      cur = g;
      chk_eq("rst_y_vld", y_vld_a[g], 64'd0);
      chk_eq("rst_y", y_a[g], 64'd0);
      chk_eq("rst_busy", busy_a[g], 64'd0);
    end

    for (int g = 0; g < N_DUT; g++) begin
      cur = g;
      idle(2);

      // Directed values including both operand extremes.
      for (int i = 0; i < 5; i++) begin
        issue(dir_v[i], 1'b1);
        drain(bc);
        chk_eq("busy_cycles", bc, iter_a[g]);
        idle(2);
      end

      // Second request while busy is dropped.
      issue(32'd49, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      issue(32'd81, 1'b0);
      drain(bc);
      idle(iter_a[g] + 4);

      // Next operand issued in the y_vld cycle.
      issue(32'd144, 1'b1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (y_vld_a[cur] !== 1'b1 && w < 40);
      chk_eq("chain_y_vld_seen", y_vld_a[cur], 64'd1);
      issue(32'd169, 1'b1);
      drain(bc);
      idle(2);

      // Reset mid-operation aborts silently.
      k_rst = (iter_a[g] < 5) ? iter_a[g] : 5;
      issue(32'd10000, 1'b0);
      repeat (k_rst - 1) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_eq("abort_busy", busy_a[cur], 64'd0);
      chk_eq("abort_y_vld", y_vld_a[cur], 64'd0);
      chk_eq("abort_y", y_a[cur], 64'd0);
      idle(iter_a[g] + 4);
      issue(32'd4, 1'b1);
      drain(bc);
      idle(2);

      // Random operands, back-to-back with occasional idle gaps.
      n_rand = (g == 0) ? 600 : ((g == 1) ? 2400 : 7000);
      issue($urandom(), 1'b1);
      for (int k = 1; k < n_rand; k++) begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (y_vld_a[cur] !== 1'b1 && w < 40);
        if (w >= 40) begin
          chk_eq("rand_y_vld_seen", y_vld_a[cur], 64'd1);
          break;
        end
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        if ((k % 4) == 0) v = $urandom_range(0, 4096);
        else v = $urandom();
        issue(v, 1'b1);
      end
      drain(bc);
      idle(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
